// File: rtl/control_unit.sv
// Microcode sequencer for the 8-bit bus computer: IR, step counter, flags and halt latch.
// Define CONTROL_UNIT_EARLY_FINISH_EN to end each instruction after its last active microstep.
module control_unit #(
  parameter int unsigned MAX_STEPS = 5,
  parameter int unsigned STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_en,
  input  logic [7:0]        bus_in,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic [15:0]       ctrl,
  output logic [3:0]        ir_operand,
  output logic [STEP_W-1:0] step,
  output logic [1:0]        flags,
  output logic              halted
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

  logic [7:0]        r_ir;
  logic [STEP_W-1:0] r_step;
  logic [1:0]        r_flags;
  logic              r_halted;

  opcode_t           w_op;
  int unsigned       w_step_idx;
  logic [15:0]       w_ctrl;
  logic              w_wrap;

  assign w_op       = opcode_t'(r_ir[7:4]);
  assign w_step_idx = 32'(r_step);

  always_comb begin : decode
    w_ctrl = '0;
    case (w_op)
      OP_LDA: case (w_step_idx)
        2:       w_ctrl = C_IO | C_MI;
        3:       w_ctrl = C_RO | C_AI;
        default: ;
      endcase
      OP_ADD, OP_SUB: case (w_step_idx)
        2:       w_ctrl = C_IO | C_MI;
        3:       w_ctrl = C_RO | C_BI;
        4:       w_ctrl = C_EO | C_AI | C_FI | ((w_op == OP_SUB) ? C_SU : '0);
        default: ;
      endcase
      OP_STA: case (w_step_idx)
        2:       w_ctrl = C_IO | C_MI;
        3:       w_ctrl = C_AO | C_RI;
        default: ;
      endcase
      OP_LDI: if (w_step_idx == 2) w_ctrl = C_IO | C_AI;
      OP_JMP: if (w_step_idx == 2) w_ctrl = C_IO | C_J;
      OP_JC:  if (w_step_idx == 2) w_ctrl = C_IO | (r_flags[1] ? C_J : '0);
      OP_JZ:  if (w_step_idx == 2) w_ctrl = C_IO | (r_flags[0] ? C_J : '0);
      OP_OUT: if (w_step_idx == 2) w_ctrl = C_AO | C_OI;
      OP_HLT: if (w_step_idx == 2) w_ctrl = C_HLT;
      default: ;
    endcase
    // Fetch microsteps are common to every opcode and override the execute table.
    if (w_step_idx == 0)
      w_ctrl = C_CO | C_MI;
    else if (w_step_idx == 1)
      w_ctrl = C_RO | C_II | C_CE;
    if (r_halted)
      w_ctrl = C_HLT;
  end

`ifdef CONTROL_UNIT_EARLY_FINISH_EN
  int unsigned w_fin_idx;

  always_comb begin : finish_step
    w_fin_idx = 1;
    case (w_op)
      OP_LDA, OP_STA:                          w_fin_idx = 3;
      OP_ADD, OP_SUB:                          w_fin_idx = 4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
      OP_HLT:                                  w_fin_idx = 2;
      default:                                 w_fin_idx = 1;
    endcase
  end

  // Truncated MAX_STEPS still wraps at LAST_STEP before a late finish index.
  assign w_wrap = (r_step == LAST_STEP) || (w_step_idx == w_fin_idx);
`else
  assign w_wrap = (r_step == LAST_STEP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir     <= '0;
      r_step   <= '0;
      r_flags  <= '0;
      r_halted <= 1'b0;
    end else if (step_en && !r_halted) begin
      if (w_ctrl[15])
        r_halted <= 1'b1;
      else if (w_wrap)
        r_step <= '0;
      else
        r_step <= r_step + STEP_W'(1);
      if (w_step_idx == 1)
        r_ir <= bus_in;
      if (w_ctrl[0])
        r_flags <= {alu_carry, alu_zero};
    end
  end

  assign ctrl       = w_ctrl;
  assign ir_operand = r_ir[3:0];
  assign step       = r_step;
  assign flags      = r_flags;
  assign halted     = r_halted;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized step_en/bus traffic
// checked against a table-driven microcode model.
module tb_control_unit;

  localparam int MS = 5;
  localparam int SW = 3;

  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000, B_RO = 16'h1000;
  localparam logic [15:0] B_IO  = 16'h0800, B_II = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
  localparam logic [15:0] B_EO  = 16'h0080, B_SU = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010;
  localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          step_en = 1'b0;
  logic [7:0]    bus_in = '0;
  logic          alu_carry = 1'b0;
  logic          alu_zero = 1'b0;
  logic [15:0]   ctrl;
  logic [3:0]    ir_operand;
  logic [SW-1:0] step;
  logic [1:0]    flags;
  logic          halted;

  control_unit #(.MAX_STEPS(MS), .STEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .bus_in(bus_in),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .ctrl(ctrl),
    .ir_operand(ir_operand), .step(step), .flags(flags), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: microcode table per opcode plus architectural state.
  logic [15:0] ucode [16][8];
  int          op_len [16];
  logic [7:0]  m_ir;
  int          m_step;
  logic [1:0]  m_flags;
  logic        m_halted;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_table();
    for (int op = 0; op < 16; op++) begin
      for (int t = 0; t < 8; t++) ucode[op][t] = '0;
      ucode[op][0] = B_CO | B_MI;
      ucode[op][1] = B_RO | B_II | B_CE;
    end
    ucode[1][2]  = B_IO | B_MI;  ucode[1][3] = B_RO | B_AI;
    ucode[2][2]  = B_IO | B_MI;  ucode[2][3] = B_RO | B_BI;  ucode[2][4] = B_EO | B_AI | B_FI;
    ucode[3][2]  = B_IO | B_MI;  ucode[3][3] = B_RO | B_BI;  ucode[3][4] = B_EO | B_AI | B_FI | B_SU;
    ucode[4][2]  = B_IO | B_MI;  ucode[4][3] = B_AO | B_RI;
    ucode[5][2]  = B_IO | B_AI;
    ucode[6][2]  = B_IO | B_J;
    ucode[7][2]  = B_IO;
    ucode[8][2]  = B_IO;
    ucode[14][2] = B_AO | B_OI;
    ucode[15][2] = B_HLT;
    for (int op = 0; op < 16; op++) begin
      op_len[op] = 0;
      for (int t = 0; t < MS; t++)
        if (ucode[op][t] != '0) op_len[op] = t + 1;
    end
  endtask

  function automatic logic [15:0] exp_ctrl();
    logic [15:0] w;
    int op;
    if (m_halted) return B_HLT;
    op = int'(m_ir[7:4]);
    w  = ucode[op][m_step];
    if (m_step == 2 && op == 7 && m_flags[1]) w = w | B_J;
    if (m_step == 2 && op == 8 && m_flags[0]) w = w | B_J;
    return w;
  endfunction

  task automatic model_edge(input logic en, input logic [7:0] b, input logic c, input logic z);
    logic [15:0] cw;
    int old, last;
    if (en && !m_halted) begin
      cw   = exp_ctrl();
      old  = m_step;
      last = MS - 1;
`ifdef CONTROL_UNIT_EARLY_FINISH_EN
      if (op_len[int'(m_ir[7:4])] - 1 < last) last = op_len[int'(m_ir[7:4])] - 1;
`endif
      if (cw[15]) m_halted = 1'b1;
      else        m_step = (m_step == last) ? 0 : m_step + 1;
      if (old == 1) m_ir = b;
      if (cw[0])    m_flags = {c, z};
    end
  endtask

  task automatic cmp_all();
    chk("ctrl", ctrl, exp_ctrl());
    chk("step", step, m_step);
    chk("flags", flags, m_flags);
    chk("halted", halted, m_halted);
    chk("ir_operand", ir_operand, m_ir[3:0]);
  endtask

  // Entered and left on a falling clock edge.
  task automatic cyc(input logic en, input logic [7:0] b, input logic c, input logic z);
    step_en = en; bus_in = b; alu_carry = c; alu_zero = z;
    @(posedge clk);
    model_edge(en, b, c, z);
    @(negedge clk);
    cmp_all();
  endtask

  // Asserts rst_n between clock edges and checks its effect before any edge arrives.
  task automatic do_reset();
    step_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_ir = '0; m_step = 0; m_flags = '0; m_halted = 1'b0;
    chk("rst_step", step, 0);
    chk("rst_ctrl", ctrl, 16'h4004);
    chk("rst_halted", halted, 0);
    chk("rst_ir", ir_operand, 0);
    cmp_all();
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_instr();
    for (int k = 0; k < 12 && m_step != 0 && !m_halted; k++)
      cyc(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
    chk("instr_end_step", step, 0);
  endtask

  task automatic to_step(input logic [7:0] instr, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, instr, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrap_exp[$];
    int saved_step;
    int hcnt;
    logic [7:0] b;

    build_table();
    @(negedge clk);
    do_reset();

    // Fetch of LDA 0xE
    cyc(1'b1, 8'h1E, 1'b0, 1'b0);
    chk("t1_ctrl", ctrl, 16'h1408);
    cyc(1'b1, 8'h1E, 1'b0, 1'b0);
    chk("lda_t2_ctrl", ctrl, 16'h4800);
    chk("lda_operand", ir_operand, 4'hE);
    finish_instr();

    // ADD producing carry
    to_step(8'h2A, 4);
    chk("add_t4_ctrl", ctrl, 16'h0281);
    cyc(1'b1, 8'h00, 1'b1, 1'b0);
    chk("add_flags", flags, 2'b10);
    finish_instr();

    to_step(8'h73, 2);
    chk("jc_taken_ctrl", ctrl, 16'h0802);
    finish_instr();

    // SUB clearing flags, then JC not taken
    to_step(8'h31, 4);
    chk("sub_t4_ctrl", ctrl, 16'h02C1);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    chk("sub_flags0", flags, 2'b00);
    finish_instr();
    to_step(8'h73, 2);
    chk("jc_not_taken_ctrl", ctrl, 16'h0800);
    finish_instr();

    // SUB giving zero, then JZ taken
    to_step(8'h31, 4);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    chk("sub_zero_flags", flags, 2'b01);
    finish_instr();
    to_step(8'h85, 2);
    chk("jz_taken_ctrl", ctrl, 16'h0802);

    // step_en idle: nothing moves
    saved_step = m_step;
    for (int k = 0; k < 100; k++) cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    chk("idle_step", step, saved_step);
    chk("idle_ctrl", ctrl, 16'h0802);
    finish_instr();

    // Step wrap sequence for LDI
    do_reset();
`ifdef CONTROL_UNIT_EARLY_FINISH_EN
    wrap_exp = '{1, 2, 0};
`else
    wrap_exp = '{1, 2, 3, 4, 0};
`endif
    foreach (wrap_exp[i]) begin
      cyc(1'b1, 8'h57, 1'b0, 1'b0);
      chk("wrap_step", step, wrap_exp[i]);
    end

    // Asynchronous reset during STA T3
    to_step(8'h4C, 3);
    chk("sta_t3_ctrl", ctrl, 16'h2100);
    do_reset();

    // HLT latches and ignores step_en
    to_step(8'hF0, 2);
    chk("hlt_t2_ctrl", ctrl, 16'h8000);
    cyc(1'b1, 8'h00, 1'b1, 1'b1);
    chk("hlt_latched", halted, 1);
    for (int k = 0; k < 10; k++) cyc(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
    chk("hlt_step_frozen", step, 2);
    chk("hlt_ctrl_frozen", ctrl, 16'h8000);
    do_reset();

    // Randomized traffic
    hcnt = 0;
    for (int k = 0; k < 3000; k++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'($urandom_range(0, 14));
      cyc(($urandom_range(0, 3) != 0), b, 1'($urandom), 1'($urandom));
      if (m_halted) hcnt++;
      if (hcnt > 4 || $urandom_range(0, 299) == 0) begin
        do_reset();
        hcnt = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
